// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch direction predictor.
// Provides the predictor FSM state enum and the weakly-not-taken counter value.
package bp_pkg;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_e;

  function automatic int unsigned weak_nt(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: counter storage, two async read ports, one sync write port.
// Ports: rd_a_idx_i/rd_a_o (lookup), rd_b_idx_i/rd_b_o (update), we_i/wr_idx_i/wr_data_i.
module bp_table #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output logic [CTR_W-1:0] rd_a_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic [CTR_W-1:0] rd_b_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [CTR_W-1:0] wr_data_i
);

  logic [CTR_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_a_o = mem_q[rd_a_idx_i];
  assign rd_b_o = mem_q[rd_b_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare direction predictor, init sweep, perf counters.
// Ports: lookup_* / predict_* (ID), update_* (EX), ready, predictions_made, correct_predictions.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 0,
  parameter int unsigned PC_LSB     = 2,
  parameter int unsigned PERF_BITS  = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  output logic                  ready,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_pred_taken,
  input  logic                  update_taken,
  output logic [PERF_BITS-1:0]  predictions_made,
  output logic [PERF_BITS-1:0]  correct_predictions
);

  // Bimodal still carries a 1-bit history register held at zero.
  localparam int unsigned GW = (GHR_BITS == 0) ? 1 : GHR_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT =
    CTR_BITS'(weak_nt(CTR_BITS));
  localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
  localparam logic [PERF_BITS-1:0] PERF_MAX = '1;

  bp_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [GW-1:0]         ghr_q, ghr_d;
  logic [PERF_BITS-1:0]  pm_q, pm_d;
  logic [PERF_BITS-1:0]  cp_q, cp_d;

  logic [INDEX_BITS-1:0] ghr_idx;
  logic [GW-1:0]         ghr_shift;
  logic [CTR_BITS-1:0]   lk_ctr;
  logic [CTR_BITS-1:0]   up_ctr;
  logic [CTR_BITS-1:0]   up_nxt;
  logic                  we;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [CTR_BITS-1:0]   wr_data;
  logic                  unused_pc;

  assign unused_pc = ^lookup_pc;

  assign ghr_idx = (GHR_BITS == 0) ? '0
                 : INDEX_BITS'(ghr_q);

  // Dropping the MSB of {ghr, taken} is the history shift.
  assign ghr_shift = (GHR_BITS == 0) ? '0
                   : GW'({ghr_q, update_taken});

  assign predict_index =
    lookup_pc[PC_LSB +: INDEX_BITS] ^ ghr_idx;

  assign ready         = (state_q == BP_READY);
  assign predict_taken = ready & lk_ctr[CTR_BITS-1];

  assign predictions_made    = pm_q;
  assign correct_predictions = cp_q;

  bp_table #(
    .IDX_W (INDEX_BITS),
    .CTR_W (CTR_BITS)
  ) u_table (
    .clk        (clk),
    .rd_a_idx_i (predict_index),
    .rd_a_o     (lk_ctr),
    .rd_b_idx_i (update_index),
    .rd_b_o     (up_ctr),
    .we_i       (we),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data)
  );

  always_comb begin
    up_nxt = up_ctr;
    unique case (1'b1)
      update_taken && (up_ctr != CTR_MAX):
        up_nxt = up_ctr + 1'b1;
      !update_taken && (up_ctr != '0):
        up_nxt = up_ctr - 1'b1;
      default:
        up_nxt = up_ctr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    pm_d    = pm_q;
    cp_d    = cp_q;
    we      = 1'b0;
    wr_idx  = update_index;
    wr_data = up_nxt;
    unique case (state_q)
      BP_INIT: begin
        we      = 1'b1;
        wr_idx  = ptr_q;
        wr_data = CTR_WNT;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = BP_READY;
      end
      BP_READY: begin
        if (lookup_valid && (pm_q != PERF_MAX))
          pm_d = pm_q + 1'b1;
        if (update_valid) begin
          we    = 1'b1;
          ghr_d = ghr_shift;
          if ((update_pred_taken == update_taken)
              && (cp_q != PERF_MAX))
            cp_d = cp_q + 1'b1;
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      pm_q    <= '0;
      cp_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      pm_q    <= pm_d;
      cp_q    <= cp_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table plus scoreboard bench for branch_predictor.
// Drives a bimodal instance and a 4-bit gshare / 3-bit perf instance.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;

  logic        lv, uv, up, ut;
  logic [31:0] pc;
  logic [7:0]  ui;
  logic        pt, rdy;
  logic [7:0]  pidx;
  logic [12:0] pm, cp;

  logic        g_lv, g_uv, g_up, g_ut;
  logic [31:0] g_pc;
  logic [7:0]  g_ui;
  logic        g_pt, g_rdy;
  logic [7:0]  g_pidx;
  logic [2:0]  g_pm, g_cp;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       pt;
    logic [7:0] idx;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic        uv;
    logic [7:0]  ui;
    logic        ut;
    logic        pt;
    logic [7:0]  idx;
  } vec_t;

  vec_t vecs[14];

  branch_predictor u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_valid        (lv),
    .lookup_pc           (pc),
    .predict_taken       (pt),
    .predict_index       (pidx),
    .ready               (rdy),
    .update_valid        (uv),
    .update_index        (ui),
    .update_pred_taken   (up),
    .update_taken        (ut),
    .predictions_made    (pm),
    .correct_predictions (cp)
  );

  branch_predictor #(
    .GHR_BITS  (4),
    .PERF_BITS (3)
  ) u_gs (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_valid        (g_lv),
    .lookup_pc           (g_pc),
    .predict_taken       (g_pt),
    .predict_index       (g_pidx),
    .ready               (g_rdy),
    .update_valid        (g_uv),
    .update_index        (g_ui),
    .update_pred_taken   (g_up),
    .update_taken        (g_ut),
    .predictions_made    (g_pm),
    .correct_predictions (g_cp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    lv = 0; uv = 0; up = 0; ut = 0;
    pc = '0; ui = '0;
    g_lv = 0; g_uv = 0; g_up = 0; g_ut = 0;
    g_pc = '0; g_ui = '0;
  endtask

  task automatic sb_check(input string nm,
                          input logic a_pt,
                          input logic [7:0] a_idx);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_pt"}, 32'(a_pt), 32'(e.pt));
      chk({nm, "_idx"}, 32'(a_idx), 32'(e.idx));
    end
  endtask

  // Runs the init sweep while hammering lookups/updates that must be ignored.
  task automatic sweep(output int n, output int bad);
    n = 0;
    bad = 0;
    lv = 1; pc = 32'h40; uv = 1; ui = 8'h10; up = 1; ut = 1;
    g_lv = 1; g_pc = 32'h40; g_uv = 1; g_ui = 8'h10;
    g_up = 1; g_ut = 1;
    while (!rdy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (!rdy && (pt || g_pt)) bad++;
      pc = n[0] ? $urandom : 32'h40;
      g_pc = n[0] ? 32'h40 : $urandom;
    end
    idle();
  endtask

  initial begin
    int n, bad;
    int exp_pm, exp_cp;
    logic [3:0] ghr_seq;
    logic [7:0] gidx [4];

    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_pm", 32'(pm), 0);
    chk("rst_cp", 32'(cp), 0);
    chk("rst_g_ready", 32'(g_rdy), 0);

    @(negedge clk);
    rst_n = 1'b1;
    sweep(n, bad);
    chk("init_len", 32'(n), 256);
    chk("init_pred_forced0", 32'(bad), 0);
    chk("init_pm_uncounted", 32'(pm), 0);
    chk("init_cp_uncounted", 32'(cp), 0);
    chk("g_ready", 32'(g_rdy), 1);

    // Every entry reads weakly not taken after the sweep.
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pc = 32'(i) << 2;
      #2;
      if (pt !== 1'b0) bad++;
    end
    chk("table_all_wnt", 32'(bad), 0);

    vecs[0]  = '{1, 32'h40, 1, 8'h10, 1, 0, 8'h10};
    vecs[1]  = '{1, 32'h40, 1, 8'h10, 1, 1, 8'h10};
    vecs[2]  = '{1, 32'h40, 1, 8'h10, 1, 1, 8'h10};
    vecs[3]  = '{1, 32'h40, 1, 8'h10, 0, 1, 8'h10};
    vecs[4]  = '{1, 32'h40, 1, 8'h10, 0, 1, 8'h10};
    vecs[5]  = '{1, 32'h40, 1, 8'h10, 0, 0, 8'h10};
    vecs[6]  = '{1, 32'h40, 1, 8'h10, 0, 0, 8'h10};
    vecs[7]  = '{1, 32'h40, 1, 8'h10, 1, 0, 8'h10};
    vecs[8]  = '{1, 32'h40, 1, 8'h10, 1, 0, 8'h10};
    vecs[9]  = '{1, 32'h41, 0, 8'h00, 0, 1, 8'h10};
    vecs[10] = '{1, 32'h44, 1, 8'h05, 1, 0, 8'h11};
    vecs[11] = '{1, 32'h14, 0, 8'h00, 0, 1, 8'h05};
    vecs[12] = '{0, 32'h3FC, 0, 8'h00, 0, 0, 8'hFF};
    vecs[13] = '{1, 32'hFFFF_FC00, 0, 8'h00, 0, 0, 8'h00};

    exp_pm = 0;
    exp_cp = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      lv = vecs[i].lv;
      pc = vecs[i].pc;
      uv = vecs[i].uv;
      ui = vecs[i].ui;
      ut = vecs[i].ut;
      up = 1'b1;
      sb.push_back('{vecs[i].pt, vecs[i].idx});
      if (vecs[i].lv) exp_pm++;
      if (vecs[i].uv && vecs[i].ut) exp_cp++;
      #2;
      sb_check($sformatf("vec%0d", i), pt, pidx);
    end
    @(negedge clk);
    idle();
    #2;
    chk("perf_pm", 32'(pm), 32'(exp_pm));
    chk("perf_cp", 32'(cp), 32'(exp_cp));

    // Gshare: history taken,taken,not,taken -> 4'b1101.
    ghr_seq = 4'b1011;
    gidx[0] = 8'h10;
    gidx[1] = 8'h11;
    gidx[2] = 8'h13;
    gidx[3] = 8'h16;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g_lv = 1; g_pc = 32'h40; g_uv = 1; g_ui = 8'h80;
      g_ut = ghr_seq[i]; g_up = ghr_seq[i];
      sb.push_back('{1'b0, gidx[i]});
      #2;
      sb_check($sformatf("g_hist%0d", i), g_pt, g_pidx);
    end
    @(negedge clk);
    g_uv = 0; g_lv = 1; g_pc = 32'h40;
    sb.push_back('{1'b0, 8'h1D});
    #2;
    sb_check("g_hist_1101", g_pt, g_pidx);
    @(negedge clk);
    idle();
    #2;
    chk("g_pm_5", 32'(g_pm), 5);
    chk("g_cp_4", 32'(g_cp), 4);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g_lv = 1; g_uv = 1; g_ui = 8'h80; g_ut = 1; g_up = 1;
    end
    @(negedge clk);
    idle();
    #2;
    chk("g_pm_sat", 32'(g_pm), 7);
    chk("g_cp_sat", 32'(g_cp), 7);

    // Reset from READY, then again mid-sweep.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst2_ready", 32'(rdy), 0);
    chk("rst2_g_pm", 32'(g_pm), 0);
    chk("rst2_g_cp", 32'(g_cp), 0);
    chk("rst2_pm", 32'(pm), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lv = 1; pc = 32'h40;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (rdy || pt) bad++;
    end
    chk("midsweep_inactive", 32'(bad), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep(n, bad);
    chk("resweep_len", 32'(n), 256);
    chk("resweep_forced0", 32'(bad), 0);

    @(negedge clk);
    lv = 1; pc = 32'h40;
    g_lv = 1; g_pc = 32'h40;
    sb.push_back('{1'b0, 8'h10});
    sb.push_back('{1'b0, 8'h10});
    #2;
    sb_check("post_rst", pt, pidx);
    sb_check("post_rst_g_ghr0", g_pt, g_pidx);
    chk("post_rst_pm", 32'(pm), 0);
    chk("post_rst_g_cp", 32'(g_cp), 0);
    @(negedge clk);
    idle();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
